// File: rtl/frisk_anim_select.sv
// frisk_anim_select
//   Picks the Frisk sprite to display and produces the registered Frisk pixel.
//   Facing direction and walk phase come from the keycode, which is sampled once
//   per frame on a tick derived from frame_clk. Sprite selection decodes direction
//   and phase. The selected ROM colour is colour-keyed against TRANSPARENT.
//
// Parameters
//   ANIM_DIV     frame ticks per walk-phase step while the same move key is held (>=1)
//   TRANSPARENT  ROM colour treated as see-through
//
// Ports
//   Clk          system clock
//   Reset_n      asynchronous, active-low reset
//   frame_clk    vsync-rate strobe, sampled in the Clk domain
//   keycode      USB keycode: 26 W up, 4 A left, 22 S down, 7 D right, else none
//   is_frisk     current pixel lies inside the Frisk box
//   rom_colors   ten packed ROM colours; [24*i+23:24*i] is sprite i+1
//   sprite_sel   active sprite number 1..10
//   frisk_pixel  registered: draw Frisk colour at this pixel
//   frisk_color  registered RGB, 0 when frisk_pixel is 0
//   walking      1 while the FSM is in WALK (also serves as the FSM state view)
module frisk_anim_select #(
    parameter int          ANIM_DIV    = 8,
    parameter logic [23:0] TRANSPARENT = 24'h000000
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         frame_clk,
    input  logic [7:0]   keycode,
    input  logic         is_frisk,
    input  logic [239:0] rom_colors,
    output logic [3:0]   sprite_sel,
    output logic         frisk_pixel,
    output logic [23:0]  frisk_color,
    output logic         walking
);

    localparam int DW = $clog2(ANIM_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic [0:0]    state;
    logic [1:0]    dir;
    logic [1:0]    phase;
    logic [DW-1:0] div_cnt;
    logic          fc_d;
    logic          tick;

    logic          key_valid;
    logic [1:0]    key_dir;
    logic [23:0]   sel_color;
    logic          pixel_next;

    // Keycode decode; anything other than the four move keys means "no key".
    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_DOWN;
        case (keycode)
            8'd26:   key_dir = DIR_UP;
            8'd4:    key_dir = DIR_LEFT;
            8'd22:   key_dir = DIR_DOWN;
            8'd7:    key_dir = DIR_RIGHT;
            default: key_valid = 1'b0;
        endcase
    end

    // Rising-edge detect on frame_clk; tick lands one Clk after the rising sample,
    // so a frame_clk held high yields exactly one tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_d <= 1'b0;
            tick <= 1'b0;
        end else begin
            fc_d <= frame_clk;
            tick <= frame_clk & ~fc_d;
        end
    end

    // Walk FSM. A direction change takes priority over a divider wrap on the same tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            dir     <= DIR_DOWN;
            phase   <= 2'd0;
            div_cnt <= '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        dir     <= key_dir;
                        phase   <= 2'd1;
                        div_cnt <= '0;
                        state   <= ST_WALK;
                    end
                end
                default: begin
                    if (!key_valid) begin
                        phase   <= 2'd0;
                        div_cnt <= '0;
                        state   <= ST_IDLE;
                    end else if (key_dir != dir) begin
                        dir     <= key_dir;
                        phase   <= 2'd1;
                        div_cnt <= '0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        phase   <= phase + 2'd1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign walking = (state == ST_WALK);

    // Phase 0 and 2 are standing frames; 1 is walk A, 3 is walk B.
    // Left/right reuse the same sprite for both walk frames.
    always_comb begin
        sprite_sel = 4'd1;
        case (dir)
            DIR_DOWN:  sprite_sel = !phase[0] ? 4'd1 : (phase[1] ? 4'd3 : 4'd2);
            DIR_UP:    sprite_sel = !phase[0] ? 4'd4 : (phase[1] ? 4'd6 : 4'd5);
            DIR_LEFT:  sprite_sel = !phase[0] ? 4'd7 : 4'd8;
            default:   sprite_sel = !phase[0] ? 4'd9 : 4'd10;
        endcase
    end

    always_comb begin
        sel_color = rom_colors[23:0];
        for (int i = 0; i < 10; i++) begin
            if (sprite_sel == 4'(i + 1)) begin
                sel_color = rom_colors[24*i +: 24];
            end
        end
    end

    assign pixel_next = is_frisk && (sel_color != TRANSPARENT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frisk_pixel <= 1'b0;
            frisk_color <= 24'h000000;
        end else begin
            frisk_pixel <= pixel_next;
            frisk_color <= pixel_next ? sel_color : 24'h000000;
        end
    end

endmodule

// File: tb/tb_frisk_anim_select.sv
module tb_frisk_anim_select;

    localparam int ANIM_DIV = 2;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         frame_clk = 1'b0;
    logic [7:0]   keycode = 8'd0;
    logic         is_frisk = 1'b0;
    logic [239:0] rom_colors = '0;
    logic [3:0]   sprite_sel;
    logic         frisk_pixel;
    logic [23:0]  frisk_color;
    logic         walking;

    int n_cmp = 0;
    int n_fail = 0;

    frisk_anim_select #(.ANIM_DIV(ANIM_DIV), .TRANSPARENT(24'h000000)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .frame_clk(frame_clk),
        .keycode(keycode),
        .is_frisk(is_frisk),
        .rom_colors(rom_colors),
        .sprite_sel(sprite_sel),
        .frisk_pixel(frisk_pixel),
        .frisk_color(frisk_color),
        .walking(walking)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    // Reference model: direction index (0 down, 1 up, 2 left, 3 right), whether
    // walking, and how many ticks the current direction has been held since it
    // was chosen. Phase follows from plain arithmetic on that count.
    int m_dir;
    bit m_walk;
    int m_held;
    int sprite_tab [4][4] = '{'{1, 2, 1, 3}, '{4, 5, 4, 6}, '{7, 8, 7, 8}, '{9, 10, 9, 10}};

    function automatic int key_to_dir(input logic [7:0] k);
        if (k == 8'd22) return 0;
        if (k == 8'd26) return 1;
        if (k == 8'd4)  return 2;
        if (k == 8'd7)  return 3;
        return -1;
    endfunction

    function automatic void model_reset();
        m_dir = 0;
        m_walk = 1'b0;
        m_held = 0;
    endfunction

    function automatic void model_tick(input logic [7:0] k);
        int d;
        d = key_to_dir(k);
        if (d < 0) begin
            m_walk = 1'b0;
            m_held = 0;
        end else if (!m_walk || d != m_dir) begin
            m_dir = d;
            m_walk = 1'b1;
            m_held = 0;
        end else begin
            m_held++;
        end
    endfunction

    function automatic int model_phase();
        return m_walk ? (1 + m_held / ANIM_DIV) % 4 : 0;
    endfunction

    function automatic logic [3:0] exp_sprite();
        return 4'(sprite_tab[m_dir][model_phase()]);
    endfunction

    function automatic logic [23:0] rom_slice(input logic [239:0] r, input int s);
        return r[24*(s-1) +: 24];
    endfunction

    // driver: one frame_clk pulse with keycode stable across the sampling edge
    task automatic drive_tick(input logic [7:0] k);
        @(negedge Clk);
        keycode = k;
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        model_tick(k);
    endtask

    task automatic rand_roms(output logic [239:0] r);
        for (int i = 0; i < 10; i++) begin
            r[24*i +: 24] = ($urandom_range(0, 3) == 0) ? 24'h000000 : 24'($urandom);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (sprite_sel !== 4'd1 || walking !== 1'b0 || frisk_pixel !== 1'b0 || frisk_color !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_initial: sel=%0d walk=%b pix=%b col=%h want sel=1 walk=0 pix=0 col=0",
                     sprite_sel, walking, frisk_pixel, frisk_color);
        end
        #2 Reset_n = 1'b1;
        // walk right, light up a pixel, then reset asynchronously mid-walk
        drive_tick(8'd7);
        rom_colors = {10{24'h123456}};
        is_frisk = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (sprite_sel !== 4'd10 || walking !== 1'b1 || frisk_pixel !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prewalk: sel=%0d walk=%b pix=%b want sel=10 walk=1 pix=1",
                     sprite_sel, walking, frisk_pixel);
        end
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (sprite_sel !== 4'd1 || walking !== 1'b0 || frisk_pixel !== 1'b0 || frisk_color !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_async: sel=%0d walk=%b pix=%b col=%h want sel=1 walk=0 pix=0 col=0",
                     sprite_sel, walking, frisk_pixel, frisk_color);
        end
        #1 Reset_n = 1'b1;
        model_reset();
        is_frisk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_walk_down();
        logic [3:0] want_seq [9] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd3, 4'd3, 4'd1, 4'd1, 4'd2};
        for (int t = 0; t < 9; t++) begin
            drive_tick(8'd22);
            n_cmp++;
            if (sprite_sel !== exp_sprite() || sprite_sel !== want_seq[t] || walking !== 1'b1) begin
                n_fail++;
                $display("FAIL walk_down tick %0d: sel=%0d walk=%b want sel=%0d walk=1",
                         t + 1, sprite_sel, walking, want_seq[t]);
            end
        end
    endtask

    task automatic test_dir_change();
        int guard = 0;
        while (model_phase() != 3 && guard < 16) begin
            drive_tick(8'd22);
            guard++;
        end
        n_cmp++;
        if (sprite_sel !== 4'd3) begin
            n_fail++;
            $display("FAIL dir_change_setup: sel=%0d want 3", sprite_sel);
        end
        drive_tick(8'd7);
        n_cmp++;
        if (sprite_sel !== 4'd10 || walking !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_change_first: sel=%0d walk=%b want sel=10 walk=1", sprite_sel, walking);
        end
        for (int t = 0; t < ANIM_DIV; t++) drive_tick(8'd7);
        n_cmp++;
        if (sprite_sel !== 4'd9 || sprite_sel !== exp_sprite()) begin
            n_fail++;
            $display("FAIL dir_change_step: sel=%0d want 9", sprite_sel);
        end
    endtask

    task automatic test_release_hold();
        logic [3:0] prev;
        int changes;
        drive_tick(8'd4);
        drive_tick(8'd0);
        n_cmp++;
        if (sprite_sel !== 4'd7 || walking !== 1'b0) begin
            n_fail++;
            $display("FAIL release_00: sel=%0d walk=%b want sel=7 walk=0", sprite_sel, walking);
        end
        drive_tick(8'd4);
        drive_tick(8'd5);
        n_cmp++;
        if (sprite_sel !== 4'd7 || walking !== 1'b0) begin
            n_fail++;
            $display("FAIL release_05: sel=%0d walk=%b want sel=7 walk=0", sprite_sel, walking);
        end
        // frame_clk held high for 100 Clk; the key changes midway and must be ignored
        @(negedge Clk);
        keycode = 8'd26;
        frame_clk = 1'b1;
        prev = sprite_sel;
        changes = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            if (c == 10) keycode = 8'd7;
            if (sprite_sel !== prev) changes++;
            prev = sprite_sel;
        end
        frame_clk = 1'b0;
        model_tick(8'd26);
        n_cmp++;
        if (sprite_sel !== exp_sprite() || walking !== 1'b1 || changes != 1) begin
            n_fail++;
            $display("FAIL hold_high: sel=%0d walk=%b changes=%0d want sel=%0d walk=1 changes=1",
                     sprite_sel, walking, changes, exp_sprite());
        end
    endtask

    task automatic test_pixel();
        logic [23:0] col_tab [3] = '{24'hffc90e, 24'h000000, 24'hffc90e};
        logic        frisk_tab [3] = '{1'b1, 1'b1, 1'b0};
        logic [239:0] r;
        logic         want_pix;
        logic [23:0]  want_col;
        n_cmp++;
        if (sprite_sel !== 4'd5) begin
            n_fail++;
            $display("FAIL pixel_setup: sel=%0d want 5", sprite_sel);
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge Clk);
            rand_roms(r);
            r[24*4 +: 24] = col_tab[t];
            rom_colors = r;
            is_frisk = frisk_tab[t];
            want_pix = frisk_tab[t] && (col_tab[t] != 24'h000000);
            want_col = want_pix ? col_tab[t] : 24'h000000;
            @(negedge Clk);
            n_cmp++;
            if (frisk_pixel !== want_pix || frisk_color !== want_col) begin
                n_fail++;
                $display("FAIL pixel_case%0d: pix=%b col=%h want pix=%b col=%h",
                         t, frisk_pixel, frisk_color, want_pix, want_col);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  keys [6] = '{8'd26, 8'd4, 8'd22, 8'd7, 8'd0, 8'd5};
        logic [7:0]  k;
        logic [239:0] r;
        logic        want_pix;
        logic [23:0] want_col;
        for (int it = 0; it < 40; it++) begin
            // bias toward repeating the key so the walk cycle actually advances
            k = ($urandom_range(0, 2) != 0) ? keycode : keys[$urandom_range(0, 5)];
            if (key_to_dir(k) < 0 && $urandom_range(0, 1) == 1) k = keys[$urandom_range(0, 3)];
            drive_tick(k);
            n_cmp++;
            if (sprite_sel !== exp_sprite() || walking !== m_walk) begin
                n_fail++;
                $display("FAIL random_tick %0d key=%0d: sel=%0d walk=%b want sel=%0d walk=%b",
                         it, k, sprite_sel, walking, exp_sprite(), m_walk);
            end
            // between ticks: keycode noise must not move sprite_sel; pixel path keeps running
            for (int c = 0; c < 3; c++) begin
                @(negedge Clk);
                keycode = keys[$urandom_range(0, 5)];
                rand_roms(r);
                rom_colors = r;
                is_frisk = 1'($urandom_range(0, 1));
                want_pix = is_frisk && (rom_slice(r, int'(exp_sprite())) != 24'h000000);
                want_col = want_pix ? rom_slice(r, int'(exp_sprite())) : 24'h000000;
                @(negedge Clk);
                n_cmp++;
                if (sprite_sel !== exp_sprite() || frisk_pixel !== want_pix || frisk_color !== want_col) begin
                    n_fail++;
                    $display("FAIL random_idle %0d.%0d: sel=%0d pix=%b col=%h want sel=%0d pix=%b col=%h",
                             it, c, sprite_sel, frisk_pixel, frisk_color, exp_sprite(), want_pix, want_col);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        drive_tick(8'd0);
        test_walk_down();
        test_dir_change();
        test_release_hold();
        test_pixel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
